// File: rtl/kairo_pkg.sv
// kairo_pkg: shared encodings for the kairo memory responder
// Contents: FSM state enum (state_t) and fault-cause enum (fault_t).
package kairo_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {FLT_NONE, FLT_MISALIGN, FLT_RANGE} fault_t;
endpackage

// File: rtl/kairo_mem_array.sv
// kairo_mem_array: word-organised backing store with byte-strobed bus port and preload port
// Ports: clk; wstb/addr/wdata bus write (addr also drives the combinational read rdata);
//        ld_en/ld_addr/ld_data whole-word preload write.
module kairo_mem_array #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic [DATA_W/8-1:0]   wstb,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [DATA_W-1:0]     ld_data,
    output logic [DATA_W-1:0]     rdata
);
    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
    // The preload is issued last so it overrides a same-edge bus write to the same word.
    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_W/8; b++)
            if (wstb[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        if (ld_en) mem[ld_addr] <= ld_data;
    end
    assign rdata = mem[addr];
endmodule

// File: rtl/kairo_mem_resp.sv
// kairo_mem_resp: single-outstanding memory responder with programmable wait states
// Ports: clk/rst (async, active-high); mem_valid/mem_addr/mem_wstb/mem_wdata request;
//        mem_ready/mem_rdata/mem_excpt registered response; wait_cyc wait states;
//        ld_en/ld_addr/ld_data backdoor preload; txn_cnt completed-transaction count.
module kairo_mem_resp
    import kairo_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W/8-1:0]   mem_wstb,
    input  logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_ready,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_excpt,
    input  logic [3:0]            wait_cyc,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [DATA_W-1:0]     ld_data,
    output logic [15:0]           txn_cnt
);
    localparam int BYTES = DATA_W/8;
    localparam int OFF   = $clog2(BYTES);
    state_t              state, state_nx;
    fault_t              fault;
    logic [3:0]          cnt, w;
    logic [ADDR_W-1:0]   addr_q, req_addr;
    logic [BYTES-1:0]    wstb_q, req_wstb, we;
    logic [DATA_W-1:0]   wdata_q, req_wdata, word;
    logic                enter;
    always_comb begin
        w         = (int'(wait_cyc) > MAX_WAIT) ? 4'(MAX_WAIT) : wait_cyc;
        // With zero wait states the response is formed on the accepting edge, before the latch fills.
        req_addr  = (state == IDLE) ? mem_addr  : addr_q;
        req_wstb  = (state == IDLE) ? mem_wstb  : wstb_q;
        req_wdata = (state == IDLE) ? mem_wdata : wdata_q;
        fault     = ((req_addr & ADDR_W'(BYTES - 1)) != '0) ? FLT_MISALIGN :
                    ((req_addr >> (OFF + DEPTH_LOG2)) != '0) ? FLT_RANGE : FLT_NONE;
        state_nx  = (state == IDLE) ? (mem_valid ? ((w == 4'd0) ? RESP : WAIT) : IDLE) :
                    (state == WAIT && mem_valid) ? ((cnt == 4'd1) ? RESP : WAIT) : IDLE;
        // Gate with rst so a clock edge during reset can never commit a bus write.
        enter     = (state_nx == RESP) && !rst;
        we        = (enter && fault == FLT_NONE) ? req_wstb : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 4'd0;
            addr_q    <= '0;
            wstb_q    <= '0;
            wdata_q   <= '0;
            mem_ready <= 1'b0;
            mem_excpt <= 1'b0;
            mem_rdata <= '0;
            txn_cnt   <= 16'd0;
        end else begin
            cnt <= (state == IDLE && mem_valid) ? w : (state == WAIT) ? cnt - 4'd1 : 4'd0;
            if (state == IDLE && mem_valid) begin
                addr_q  <= mem_addr;
                wstb_q  <= mem_wstb;
                wdata_q <= mem_wdata;
            end
            mem_ready <= enter;
            mem_excpt <= enter && fault != FLT_NONE;
            mem_rdata <= (enter && fault == FLT_NONE) ? word : '0;
            txn_cnt   <= txn_cnt + 16'(enter);
        end
    end
    kairo_mem_array #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_mem (
        .clk     (clk),
        .wstb    (we),
        .addr    (req_addr[OFF +: DEPTH_LOG2]),
        .wdata   (req_wdata),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .rdata   (word)
    );
endmodule
